// File: rtl/wb_regfile_if.sv
// Bus bundle between the pipeline and the write-back/register-file block.
// Carries the W-stage commit fields, the two decode read ports, the debug
// read port and the architectural status outputs.
interface wb_regfile_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
);
    // W pipeline register outputs
    logic             W_stall;
    logic [1:0]       W_stat;
    logic [3:0]       W_icode;
    logic [3:0]       W_dstE;
    logic [3:0]       W_dstM;
    logic [WIDTH-1:0] W_valE;
    logic [WIDTH-1:0] W_valM;

    // Decode-stage read ports
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [WIDTH-1:0] d_rvalA;
    logic [WIDTH-1:0] d_rvalB;

    // Debug read port
    logic [3:0]       dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    // Architectural status
    logic [1:0]       proc_stat;
    logic             halted;
    logic [CNT_W-1:0] retired;

    // Pipeline side: drives W fields and read addresses
    modport master (
        output W_stall, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM,
        output d_srcA, d_srcB, dbg_addr,
        input  d_rvalA, d_rvalB, dbg_data,
        input  proc_stat, halted, retired
    );

    // Register-file side: consumes W fields, serves reads and status
    modport slave (
        input  W_stall, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM,
        input  d_srcA, d_srcB, dbg_addr,
        output d_rvalA, d_rvalB, dbg_data,
        output proc_stat, halted, retired
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage and program register file of the pipelined Y86-64 core.
// Commits valE/valM from the W register into 15 program registers, serves
// the decode read ports combinationally, and keeps a sticky RUN/HALT/FAULT
// status plus a retired-instruction counter.
module wb_regfile #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_regfile_if.slave  bus
);

    localparam int         NUM_REGS  = 15;
    localparam logic [1:0] STAT_AOK  = 2'b00;
    localparam logic [1:0] STAT_HLT  = 2'b01;
    localparam logic [3:0] ICODE_NOP = 4'h1;

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_HALT  = 2'b01,
        S_FAULT = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             commit;      // W entry is architecturally committed this cycle
    logic             count_en;    // committed entry is a real instruction
    logic             trap;        // W entry raises HLT/ADR/INS while running
    logic             halted;

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [1:0]       proc_stat;
    logic [CNT_W-1:0] retired;

    logic [WIDTH-1:0] rval_a;
    logic [WIDTH-1:0] rval_b;
    logic [WIDTH-1:0] dbg_val;

    // State register: HALT and FAULT are left only through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a stalled W entry never triggers a transition
    always_comb begin
        state_next = state;
        case (state)
            S_RUN: begin
                if (!bus.W_stall && bus.W_stat != STAT_AOK) begin
                    if (bus.W_stat == STAT_HLT) begin
                        state_next = S_HALT;
                    end else begin
                        state_next = S_FAULT;
                    end
                end
            end
            S_HALT:  state_next = S_HALT;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_FAULT;
        endcase
    end

    // Output decode: commit only while running with an unstalled AOK entry
    always_comb begin
        commit   = (state == S_RUN) && !bus.W_stall && (bus.W_stat == STAT_AOK);
        trap     = (state == S_RUN) && !bus.W_stall && (bus.W_stat != STAT_AOK);
        count_en = commit && (bus.W_icode != ICODE_NOP);
        halted   = (state != S_RUN);
    end

    // Status latch: captures the W_stat that caused the stop, then holds it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proc_stat <= STAT_AOK;
        end else if (trap) begin
            proc_stat <= bus.W_stat;
        end
    end

    // Retired counter: wraps silently at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (count_en) begin
            retired <= retired + CNT_W'(1);
        end
    end

    // Register file write: dstM is checked first so valM wins on a shared
    // destination (popq %rsp); index 4'hF never matches any entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.W_dstM == 4'(i)) begin
                    regs[i] <= bus.W_valM;
                end else if (bus.W_dstE == 4'(i)) begin
                    regs[i] <= bus.W_valE;
                end
            end
        end
    end

    // Read ports: plain array reads with no write-through; address 4'hF
    // matches nothing and therefore reads as zero
    always_comb begin
        rval_a  = '0;
        rval_b  = '0;
        dbg_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.d_srcA == 4'(i)) begin
                rval_a = regs[i];
            end
            if (bus.d_srcB == 4'(i)) begin
                rval_b = regs[i];
            end
            if (bus.dbg_addr == 4'(i)) begin
                dbg_val = regs[i];
            end
        end
    end

    // Drive the bus outputs
    always_comb begin
        bus.d_rvalA   = rval_a;
        bus.d_rvalB   = rval_b;
        bus.dbg_data  = dbg_val;
        bus.proc_stat = proc_stat;
        bus.halted    = halted;
        bus.retired   = retired;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a vector table for single-cycle commits
// followed by hand-written stall, wrap, halt, fault and reset sequences.
// CNT_W is reduced to 4 so the counter wrap is reachable.
module tb_wb_regfile;

    localparam int WIDTH = 64;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;

    wb_regfile_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    wb_regfile #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  chk;    // register to observe
        logic [63:0] pre;    // its value before the edge
        logic [63:0] post;   // its value after the edge
        logic [3:0]  ret;    // retired count after the edge
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_w(input logic stall, input logic [1:0] stat, input logic [3:0] icode,
                           input logic [3:0] dste, input logic [3:0] dstm,
                           input logic [63:0] vale, input logic [63:0] valm);
        bus.W_stall = stall;
        bus.W_stat  = stat;
        bus.W_icode = icode;
        bus.W_dstE  = dste;
        bus.W_dstM  = dstm;
        bus.W_valE  = vale;
        bus.W_valM  = valm;
    endtask

    task automatic bubble();
        drive_w(1'b0, 2'b00, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
    endtask

    task automatic read_dbg(input logic [3:0] a, output logic [63:0] d);
        bus.dbg_addr = a;
        #1;
        d = bus.dbg_data;
    endtask

    // Present W fields on the current negedge, cross one posedge, then
    // put a bubble on W; returns 1ns after the posedge
    task automatic commit_one(input logic stall, input logic [1:0] stat, input logic [3:0] icode,
                              input logic [3:0] dste, input logic [3:0] dstm,
                              input logic [63:0] vale, input logic [63:0] valm);
        drive_w(stall, stat, icode, dste, dstm, vale, valm);
        @(posedge clk);
        #1;
        bubble();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        n_tests = 0;
        n_fail  = 0;

        //                stall stat   icode dstE  dstM  valE                    valM      chk   pre                     post                    ret
        vecs[0] = '{1'b0, 2'b00, 4'h3, 4'h2, 4'hF, 64'h1234,               64'h0,    4'h2, 64'h0,                  64'h1234,               4'd1};
        vecs[1] = '{1'b0, 2'b00, 4'h5, 4'h4, 4'h4, 64'hAA,                 64'hBB,   4'h4, 64'h0,                  64'hBB,                 4'd2};
        vecs[2] = '{1'b0, 2'b00, 4'h5, 4'h4, 4'hF, 64'hAA,                 64'hBB,   4'h4, 64'hBB,                 64'hAA,                 4'd3};
        vecs[3] = '{1'b0, 2'b00, 4'h1, 4'hF, 4'hF, 64'h0,                  64'h0,    4'h2, 64'h1234,               64'h1234,               4'd3};
        vecs[4] = '{1'b0, 2'b00, 4'h2, 4'hE, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,   4'hE, 64'h0,                  64'hFFFF_FFFF_FFFF_FFFF, 4'd4};
        vecs[5] = '{1'b0, 2'b00, 4'h5, 4'h0, 4'h7, 64'h8000_0000_0000_0001, 64'h77,  4'h0, 64'h0,                  64'h8000_0000_0000_0001, 4'd5};
        vecs[6] = '{1'b0, 2'b00, 4'h1, 4'hF, 4'hF, 64'h0,                  64'h0,    4'h7, 64'h77,                 64'h77,                 4'd5};
        vecs[7] = '{1'b1, 2'b00, 4'h2, 4'h6, 4'hF, 64'h66,                 64'h0,    4'h6, 64'h0,                  64'h0,                  4'd5};
        vecs[8] = '{1'b0, 2'b00, 4'h6, 4'hF, 4'hF, 64'h99,                 64'h0,    4'h0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 4'd6};
        vecs[9] = '{1'b0, 2'b00, 4'h3, 4'hF, 4'hF, 64'h99,                 64'h0,    4'hF, 64'h0,                  64'h0,                  4'd7};

        rst_n        = 1'b0;
        bus.d_srcA   = 4'hF;
        bus.d_srcB   = 4'hF;
        bus.dbg_addr = 4'hF;
        bubble();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        for (int i = 0; i < 16; i++) begin
            read_dbg(4'(i), d);
            check($sformatf("reset_reg%0d", i), d, 64'h0);
        end
        check("reset_proc_stat", 64'(bus.proc_stat), 64'h0);
        check("reset_halted", 64'(bus.halted), 64'h0);
        check("reset_retired", 64'(bus.retired), 64'h0);

        // Table-driven single commits
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            drive_w(vecs[v].stall, vecs[v].stat, vecs[v].icode, vecs[v].dstE, vecs[v].dstM,
                    vecs[v].valE, vecs[v].valM);
            bus.d_srcA = vecs[v].chk;
            #1;
            check($sformatf("v%0d_pre_rvalA", v), bus.d_rvalA, vecs[v].pre);
            @(posedge clk);
            #1;
            bubble();
            bus.d_srcB = vecs[v].chk;
            read_dbg(vecs[v].chk, d);
            check($sformatf("v%0d_post_dbg", v), d, vecs[v].post);
            check($sformatf("v%0d_post_rvalB", v), bus.d_rvalB, vecs[v].post);
            check($sformatf("v%0d_retired", v), 64'(bus.retired), 64'(vecs[v].ret));
            check($sformatf("v%0d_halted", v), 64'(bus.halted), 64'h0);
        end

        // Held W entry: no effect while stalled, committed once on release
        @(negedge clk);
        drive_w(1'b1, 2'b00, 4'h3, 4'h1, 4'hF, 64'h5, 64'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            read_dbg(4'h1, d);
            check($sformatf("stall%0d_reg1", c), d, 64'h0);
            check($sformatf("stall%0d_retired", c), 64'(bus.retired), 64'd7);
        end
        @(negedge clk);
        bus.W_stall = 1'b0;
        @(posedge clk);
        #1;
        bubble();
        read_dbg(4'h1, d);
        check("release_reg1", d, 64'h5);
        check("release_retired", 64'(bus.retired), 64'd8);
        @(posedge clk);
        #1;
        check("release_once_retired", 64'(bus.retired), 64'd8);

        // Counter wrap: 8 -> 15 -> 0
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            commit_one(1'b0, 2'b00, 4'h6, 4'hF, 4'hF, 64'h0, 64'h0);
        end
        check("wrap_allones", 64'(bus.retired), 64'd15);
        @(negedge clk);
        commit_one(1'b0, 2'b00, 4'h6, 4'hF, 4'hF, 64'h0, 64'h0);
        check("wrap_zero", 64'(bus.retired), 64'd0);

        // HALT: trapping instruction does not write; state is sticky
        @(negedge clk);
        drive_w(1'b0, 2'b01, 4'h0, 4'h3, 4'hF, 64'h77, 64'h0);
        #1;
        check("halt_pre_halted", 64'(bus.halted), 64'h0);
        @(posedge clk);
        #1;
        bubble();
        read_dbg(4'h3, d);
        check("halt_reg3", d, 64'h0);
        check("halt_proc_stat", 64'(bus.proc_stat), 64'h1);
        check("halt_halted", 64'(bus.halted), 64'h1);
        check("halt_retired", 64'(bus.retired), 64'd0);
        @(negedge clk);
        commit_one(1'b0, 2'b00, 4'h3, 4'h3, 4'hF, 64'h5, 64'h0);
        read_dbg(4'h3, d);
        check("halt_ignored_reg3", d, 64'h0);
        check("halt_ignored_retired", 64'(bus.retired), 64'd0);
        @(negedge clk);
        commit_one(1'b0, 2'b10, 4'h3, 4'hF, 4'hF, 64'h0, 64'h0);
        check("halt_sticky_stat", 64'(bus.proc_stat), 64'h1);
        check("halt_sticky_halted", 64'(bus.halted), 64'h1);

        // Asynchronous reset between edges clears everything at once
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        read_dbg(4'h2, d);
        check("areset_reg2", d, 64'h0);
        check("areset_proc_stat", 64'(bus.proc_stat), 64'h0);
        check("areset_halted", 64'(bus.halted), 64'h0);
        rst_n = 1'b1;

        // FAULT on ADR, sticky against a later INS
        @(negedge clk);
        commit_one(1'b0, 2'b10, 4'h5, 4'h5, 4'hF, 64'h9, 64'h0);
        read_dbg(4'h5, d);
        check("fault_reg5", d, 64'h0);
        check("fault_proc_stat", 64'(bus.proc_stat), 64'h2);
        check("fault_halted", 64'(bus.halted), 64'h1);
        @(negedge clk);
        commit_one(1'b0, 2'b11, 4'h3, 4'hF, 4'hF, 64'h0, 64'h0);
        check("fault_sticky_stat", 64'(bus.proc_stat), 64'h2);

        // Reset held across an edge discards a pending AOK commit
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        drive_w(1'b0, 2'b00, 4'h3, 4'h5, 4'hF, 64'h9, 64'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        bubble();
        read_dbg(4'h5, d);
        check("rst_pending_reg5", d, 64'h0);
        check("rst_pending_retired", 64'(bus.retired), 64'd0);
        check("rst_pending_halted", 64'(bus.halted), 64'h0);

        // Fresh run: commit works again, then INS faults with stat 11
        @(negedge clk);
        commit_one(1'b0, 2'b00, 4'h3, 4'h5, 4'hF, 64'h9, 64'h0);
        read_dbg(4'h5, d);
        check("rerun_reg5", d, 64'h9);
        check("rerun_retired", 64'(bus.retired), 64'd1);
        @(negedge clk);
        commit_one(1'b0, 2'b11, 4'h3, 4'h5, 4'hF, 64'h1, 64'h0);
        read_dbg(4'h5, d);
        check("ins_reg5", d, 64'h9);
        check("ins_proc_stat", 64'(bus.proc_stat), 64'h3);
        check("ins_halted", 64'(bus.halted), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
